// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result reader: default bus word width,
// operation-select width, the bit positions of the one-hot ALU operations and
// the transfer FSM state type.
// Optional build macro used by the reader: ALU_RES_FLAGS_EN (zero/negative flags).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int BITS      = 32;  // operand / bus word width
  localparam int SIG_COUNT = 12;  // width of the one-hot operation select

  // Bit positions inside ctrl_signal
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;  // double-width result
  localparam int OP_DIV = 3;  // double-width result (quotient/remainder)
  localparam int OP_AND = 8;
  localparam int OP_OR  = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

endpackage : alu_pkg

// File: rtl/alu_result_reader_if.sv
// -----------------------------------------------------------------------------
// alu_result_reader_if
// Groups the ALU-side result handshake and the bus-side word handshake plus
// the status outputs of the reader.
//   master : the environment (ALU producer and bus consumer)
//   slave  : the alu_result_reader itself
// -----------------------------------------------------------------------------
interface alu_result_reader_if #(
  parameter int BITS      = alu_pkg::BITS,
  parameter int SIG_COUNT = alu_pkg::SIG_COUNT
);

  logic [SIG_COUNT-1:0] ctrl_signal;  // one-hot op select for op_result
  logic [2*BITS-1:0]    op_result;    // {Hi, Lo}
  logic                 res_valid;
  logic                 res_ready;
  logic [BITS-1:0]      bus_data;
  logic                 bus_valid;
  logic                 bus_ready;
  logic [3:0]           op_code;      // index of captured select, 4'hF if not one-hot
  logic                 ctrl_err;     // sticky non-one-hot indication
  logic [7:0]           beat_count;   // completed bus beats, wraps
  logic                 z_flag;
  logic                 n_flag;

  modport master (
    output ctrl_signal, op_result, res_valid, bus_ready,
    input  res_ready, bus_data, bus_valid, op_code, ctrl_err, beat_count,
           z_flag, n_flag
  );

  modport slave (
    input  ctrl_signal, op_result, res_valid, bus_ready,
    output res_ready, bus_data, bus_valid, op_code, ctrl_err, beat_count,
           z_flag, n_flag
  );

endinterface : alu_result_reader_if

// File: rtl/onehot_encoder.sv
// -----------------------------------------------------------------------------
// onehot_encoder
// Converts a one-hot select into its binary bit index. Any select that is not
// exactly one-hot (no bit or several bits set) yields idx = 4'hF and err = 1.
// Ports:
//   sig  in  SIG_COUNT  one-hot select
//   idx  out 4          binary index of the set bit, or 4'hF
//   err  out 1          select was not one-hot
// -----------------------------------------------------------------------------
module onehot_encoder #(
  parameter int SIG_COUNT = alu_pkg::SIG_COUNT
) (
  input  logic [SIG_COUNT-1:0] sig,
  output logic [3:0]           idx,
  output logic                 err
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned and no latch forms.
  always_comb begin
    idx = 4'd0;
    err = ($countones(sig) != 1);
    for (int i = 0; i < SIG_COUNT; i++) begin
      if (sig[i]) idx = 4'(i);
    end
    if (err) idx = 4'hF;
  end

endmodule : onehot_encoder

// File: rtl/alu_result_reader.sv
// -----------------------------------------------------------------------------
// alu_result_reader
// Captures one ALU result (with the one-hot select that produced it) and
// forwards it onto a BITS-wide valid/ready bus: MUL/DIV results go out as two
// beats (Lo then Hi), everything else (including non-one-hot selects) as Lo
// only. No new result is accepted until the transfer completes.
// Ports:
//   clk  in   single clock, rising edge
//   clr  in   asynchronous active-high reset
//   bus  slave modport of alu_result_reader_if (result handshake, bus
//        handshake, op_code, ctrl_err, beat_count, z_flag, n_flag)
// Build macro: ALU_RES_FLAGS_EN enables the zero/negative flags of the
// captured result; without it z_flag/n_flag are tied to 0.
// -----------------------------------------------------------------------------
module alu_result_reader #(
  parameter int BITS      = alu_pkg::BITS,
  parameter int SIG_COUNT = alu_pkg::SIG_COUNT
) (
  input  logic                clk,
  input  logic                clr,
  alu_result_reader_if.slave  bus
);

  import alu_pkg::state_e;
  import alu_pkg::IDLE;
  import alu_pkg::SEND_LO;
  import alu_pkg::SEND_HI;
  import alu_pkg::OP_MUL;
  import alu_pkg::OP_DIV;

  state_e            state_q, state_d;
  logic [2*BITS-1:0] data_q, data_d;
  logic              wide_q, wide_d;
  logic [3:0]        op_code_q, op_code_d;
  logic              ctrl_err_q, ctrl_err_d;
  logic [7:0]        beat_count_q, beat_count_d;

  logic [3:0] enc_idx;
  logic       enc_err;
  logic       capture;
  logic       cap_wide;
  logic       beat;

  onehot_encoder #(.SIG_COUNT(SIG_COUNT)) u_enc (
    .sig (bus.ctrl_signal),
    .idx (enc_idx),
    .err (enc_err)
  );

  // Accepting only in IDLE is the whole back-pressure mechanism: res_ready is
  // a pure state decode, so there is no bypass path.
  assign capture  = bus.res_valid && (state_q == IDLE);
  // A corrupt select never triggers a second beat, even if MUL/DIV bits are set.
  assign cap_wide = !enc_err && (bus.ctrl_signal[OP_MUL] || bus.ctrl_signal[OP_DIV]);
  assign beat     = (state_q != IDLE) && bus.bus_ready;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    wide_d       = wide_q;
    op_code_d    = op_code_q;
    ctrl_err_d   = ctrl_err_q;
    beat_count_d = beat_count_q;

    bus.res_ready = (state_q == IDLE);
    bus.bus_valid = (state_q != IDLE);
    bus.bus_data  = '0;

    if (beat) beat_count_d = beat_count_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          data_d     = bus.op_result;
          wide_d     = cap_wide;
          op_code_d  = enc_idx;
          ctrl_err_d = ctrl_err_q | enc_err;
          state_d    = SEND_LO;
        end
      end
      SEND_LO: begin
        bus.bus_data = data_q[BITS-1:0];
        if (bus.bus_ready) state_d = wide_q ? SEND_HI : IDLE;
      end
      SEND_HI: begin
        bus.bus_data = data_q[2*BITS-1:BITS];
        if (bus.bus_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      data_q       <= '0;
      wide_q       <= 1'b0;
      op_code_q    <= 4'd0;
      ctrl_err_q   <= 1'b0;
      beat_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      wide_q       <= wide_d;
      op_code_q    <= op_code_d;
      ctrl_err_q   <= ctrl_err_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign bus.op_code    = op_code_q;
  assign bus.ctrl_err   = ctrl_err_q;
  assign bus.beat_count = beat_count_q;

`ifdef ALU_RES_FLAGS_EN
  logic z_q, z_d;
  logic n_q, n_d;

  // Flags describe the result as the consumer will see it: the full
  // double word for wide ops, only Lo otherwise.
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    if (capture) begin
      if (cap_wide) begin
        z_d = (bus.op_result == '0);
        n_d = bus.op_result[2*BITS-1];
      end else begin
        z_d = (bus.op_result[BITS-1:0] == '0);
        n_d = bus.op_result[BITS-1];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign bus.z_flag = z_q;
  assign bus.n_flag = n_q;
`else
  assign bus.z_flag = 1'b0;
  assign bus.n_flag = 1'b0;
`endif

endmodule : alu_result_reader

// File: doc/alu_result_reader.md
ALU_RESULT_READER -- requirements
Module: alu_result_reader

Interface
REQ-001 Parameter BITS, default 32, operand/bus word width.
REQ-002 Parameter SIG_COUNT, default 12, width of one-hot ALU operation select.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 ctrl_signal  input  SIG_COUNT  one-hot operation select that produced op_result.
REQ-006 op_result  input  2*BITS  ALU result; [BITS-1:0]=Lo, [2*BITS-1:BITS]=Hi.
REQ-007 res_valid  input  1  result/ctrl_signal valid this cycle.
REQ-008 res_ready  output  1  unit can accept a result.
REQ-009 bus_data  output  BITS  result word driven to the bus.
REQ-010 bus_valid  output  1  bus_data valid.
REQ-011 bus_ready  input  1  bus consumer accepts bus_data this cycle.
REQ-012 op_code  output  4  binary index of the captured ctrl_signal bit; 4'hF if ctrl_signal was not one-hot.
REQ-013 ctrl_err  output  1  sticky flag: a non-one-hot ctrl_signal was accepted.
REQ-014 beat_count  output  8  count of completed bus beats.
REQ-015 z_flag, n_flag  output  1 each  zero/negative flags of the captured result.

Function
REQ-016 FSM states: IDLE, SEND_LO, SEND_HI.
REQ-017 res_ready SHALL be 1 only in IDLE; no accept during SEND_LO/SEND_HI, with no bypass.
REQ-018 A capture (res_valid & res_ready at an edge) SHALL register op_result, op_code and width class, then enter SEND_LO.
REQ-019 bus_valid SHALL be 1 in SEND_LO/SEND_HI, from the cycle after capture (latency 1), and 0 in IDLE.
REQ-020 SEND_LO SHALL drive Lo; SEND_HI SHALL drive Hi; bus_data SHALL be 0 while bus_valid=0.
REQ-021 Wide ops (ctrl_signal bit 2 MUL, bit 3 DIV) SHALL transfer two beats, Lo then Hi; all other ops and non-one-hot selects SHALL transfer Lo only.
REQ-022 SEND_LO with bus_ready: wide -> SEND_HI, otherwise -> IDLE; SEND_HI with bus_ready -> IDLE.
REQ-023 While bus_valid=1 and bus_ready=0, bus_data, op_code and state SHALL hold unchanged; bus_valid SHALL NOT retract.
REQ-024 beat_count SHALL increment on every bus_valid & bus_ready edge, wrapping 8'hFF -> 8'h00.
REQ-025 Non-one-hot ctrl_signal (zero or more than one bit set) SHALL still be accepted, with op_code=4'hF and ctrl_err set until clr.
REQ-026 res_valid arriving outside IDLE SHALL be ignored with no state effect.

Reset
REQ-027 clr SHALL asynchronously force: state IDLE, res_ready 1, bus_valid 0, bus_data 0, op_code 0, ctrl_err 0, beat_count 0, z_flag 0, n_flag 0.
REQ-028 clr asserted mid-transfer SHALL abandon the transfer with no further beats after release.

Configuration
REQ-029 Macro ALU_RES_FLAGS_EN defined: at capture, z_flag=(captured result==0) and n_flag=MSB of the captured result. Wide results use all 2*BITS bits and bit 2*BITS-1; narrow results use Lo and bit BITS-1.
REQ-030 Macro undefined: z_flag and n_flag SHALL remain present and tied to 0, with no flag logic synthesized.

Structure
REQ-031 Shared package alu_pkg SHALL hold BITS, SIG_COUNT, operation bit indices (ADD=0, SUB=1, MUL=2, DIV=3, AND=8, OR=9) and the FSM state enum.
REQ-032 Sub-module onehot_encoder (SIG_COUNT -> 4-bit index plus error flag) SHALL produce op_code and the non-one-hot detection.

Verification
REQ-033 ADD: ctrl=bit0, op_result=64'h14, bus_ready=1 -> one beat 32'h14, op_code 0, beat_count 1, back to IDLE.
REQ-034 MUL: ctrl=bit2, op_result=64'hFFFF_FFFF_FFFF_FFB5 (15*-5) -> beats 32'hFFFFFFB5 then 32'hFFFFFFFF; with ALU_RES_FLAGS_EN, n_flag=1 and z_flag=0.
REQ-035 DIV backpressure: ctrl=bit3, Lo=32'hFFFFFFFD, Hi=0, bus_ready low 5 cycles -> bus_valid and data stable, res_ready 0, a res_valid pulse is ignored; then 2 beats.
REQ-036 ctrl=12'b0000_0000_0011 -> op_code 4'hF, ctrl_err 1 sticky across later valid ops, single beat.
REQ-037 clr pulsed during SEND_HI -> bus_valid 0 immediately, then IDLE with all outputs at reset values.
REQ-038 256 consecutive narrow beats -> beat_count returns to 8'h00.
